// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
package lcd_seq_pkg;

    typedef enum logic [3:0] {
        ST_POR_WAIT   = 4'd0,
        ST_INIT_ISSUE = 4'd1,
        ST_W_SETUP    = 4'd2,
        ST_W_ENABLE   = 4'd3,
        ST_W_HOLD     = 4'd4,
        ST_R_SETUP    = 4'd5,
        ST_R_ENABLE   = 4'd6,
        ST_R_HOLD     = 4'd7,
        ST_IDLE       = 4'd8
    } state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam int         INIT_LEN     = 4;

    // Power-on init table lookup.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_phase.sv
// Loadable down-counter. A load of N makes done rise on the Nth cycle after it.
module lcd_bus_phase #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign done = (cnt_q == W'(1));
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_command_sequencer.sv
// HD44780 init + byte sequencer driving the Avalon-MM character-LCD slave.
module lcd_command_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int SETUP_CYCLES       = 3,
    parameter int ENABLE_CYCLES      = 13,
    parameter int HOLD_CYCLES        = 3,
    parameter int POR_DELAY_CYCLES   = 750000,
    parameter int BUSY_TIMEOUT_POLLS = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    output logic [1:0] lcd_address,
    output logic       lcd_write,
    output logic       lcd_read,
    output logic       lcd_begintransfer,
    output logic [7:0] lcd_writedata,
    input  logic [7:0] lcd_readdata,
    output logic       init_done,
    output logic       busy_timeout
);

    localparam int PH_SE  = (SETUP_CYCLES > ENABLE_CYCLES) ? SETUP_CYCLES : ENABLE_CYCLES;
    localparam int PH_MAX = (PH_SE > HOLD_CYCLES) ? PH_SE : HOLD_CYCLES;
    localparam int PW     = $clog2(PH_MAX) + 1;
    localparam int POR_W  = $clog2(POR_DELAY_CYCLES + 1);
    localparam int PC_W   = $clog2(BUSY_TIMEOUT_POLLS + 1);

    state_e            state_q, state_d;
    logic              rs_q, rs_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [2:0]        idx_q, idx_d;
    logic [PC_W-1:0]   poll_q, poll_d, poll_next;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              timeout_q, timeout_d;
    logic              wr_q, wr_d, rd_q, rd_d, bt_q, bt_d, rdy_q, rdy_d;
    logic [1:0]        addr_q, addr_d;

    logic              phase_load, phase_done, phase_zero_unused;
    logic [PW-1:0]     phase_val;
    logic              por_load, por_done, por_zero, por_go;
    logic              status_unused;

    assign status_unused = ^lcd_readdata[6:0];

    lcd_bus_phase #(.W(PW)) u_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (phase_load),
        .load_val (phase_val),
        .done     (phase_done),
        .zero     (phase_zero_unused)
    );

    // POR counter is loaded on the first post-reset cycle, so its zero reset value holds.
    assign por_load = (state_q == ST_POR_WAIT) && por_zero;
    assign por_go   = por_done || (POR_DELAY_CYCLES <= 1);

    lcd_bus_phase #(.W(POR_W)) u_por (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (por_load),
        .load_val (POR_W'(POR_DELAY_CYCLES - 1)),
        .done     (por_done),
        .zero     (por_zero)
    );

    // Next state, latched byte/flags, and the registered bus outputs.
    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        timeout_d   = timeout_q;
        poll_next   = (poll_q < PC_W'(BUSY_TIMEOUT_POLLS)) ? poll_q + 1'b1 : poll_q;

        case (state_q)
            ST_POR_WAIT:   if (por_go) state_d = ST_INIT_ISSUE;
            ST_INIT_ISSUE: begin
                wdata_d = init_cmd(idx_q[1:0]);
                rs_d    = 1'b0;
                idx_d   = idx_q + 1'b1;
                state_d = ST_W_SETUP;
            end
            ST_IDLE: if (in_valid) begin
                wdata_d = in_data;
                rs_d    = in_rs;
                state_d = ST_W_SETUP;
            end
            ST_W_SETUP: begin
                poll_d = '0;
                if (phase_done) state_d = ST_W_ENABLE;
            end
            ST_W_ENABLE: if (phase_done) state_d = ST_W_HOLD;
            ST_W_HOLD:   if (phase_done) state_d = ST_R_SETUP;
            ST_R_SETUP:  if (phase_done) state_d = ST_R_ENABLE;
            ST_R_ENABLE: if (phase_done) begin
                busy_d  = lcd_readdata[7];
                state_d = ST_R_HOLD;
            end
            ST_R_HOLD: if (phase_done) begin
                poll_d = poll_next;
                if (busy_q && (poll_next < PC_W'(BUSY_TIMEOUT_POLLS))) begin
                    state_d = ST_R_SETUP;
                end else begin
                    // Exhausted polls are treated as "not busy" so the stream never wedges.
                    if (busy_q) timeout_d = 1'b1;
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 3'(INIT_LEN)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_INIT_ISSUE;
                    end
                end
            end
            default: state_d = ST_POR_WAIT;
        endcase

        phase_load = (state_d != state_q);
        case (state_d)
            ST_W_SETUP, ST_R_SETUP:   phase_val = PW'(SETUP_CYCLES);
            ST_W_ENABLE, ST_R_ENABLE: phase_val = PW'(ENABLE_CYCLES);
            ST_W_HOLD, ST_R_HOLD:     phase_val = PW'(HOLD_CYCLES);
            default:                  phase_val = '0;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        wr_d  = (state_d == ST_W_ENABLE);
        rd_d  = (state_d == ST_R_ENABLE);
        bt_d  = (wr_d && state_q != ST_W_ENABLE) || (rd_d && state_q != ST_R_ENABLE);
        rdy_d = (state_d == ST_IDLE);
        case (state_d)
            ST_W_SETUP, ST_W_ENABLE, ST_W_HOLD: addr_d = {rs_d, 1'b0};
            ST_R_SETUP, ST_R_ENABLE, ST_R_HOLD: addr_d = 2'b01;
            default:                            addr_d = addr_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_POR_WAIT;
            rs_q        <= 1'b0;
            wdata_q     <= 8'h00;
            idx_q       <= '0;
            poll_q      <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            bt_q        <= 1'b0;
            rdy_q       <= 1'b0;
            addr_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            timeout_q   <= timeout_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            bt_q        <= bt_d;
            rdy_q       <= rdy_d;
            addr_q      <= addr_d;
        end
    end

    assign in_ready          = rdy_q;
    assign lcd_address       = addr_q;
    assign lcd_write         = wr_q;
    assign lcd_read          = rd_q;
    assign lcd_begintransfer = bt_q;
    assign lcd_writedata     = wdata_q;
    assign init_done         = init_done_q;
    assign busy_timeout      = timeout_q;

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Directed + randomized bench for lcd_command_sequencer with a responsive LCD model.
module tb_lcd_command_sequencer;

    localparam int POR  = 20;
    localparam int SU   = 2;
    localparam int EN   = 4;
    localparam int HO   = 2;
    localparam int TO   = 3;
    localparam int PH   = SU + EN + HO;       // one bus cycle
    localparam int CMDT = 1 + 2 * PH;         // init entry: issue + write + one poll

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_rs = 1'b0;
    logic [1:0] lcd_address;
    logic       lcd_write, lcd_read, lcd_begintransfer;
    logic [7:0] lcd_writedata;
    logic [7:0] lcd_readdata = 8'h00;
    logic       init_done, busy_timeout;

    lcd_command_sequencer #(
        .SETUP_CYCLES       (SU),
        .ENABLE_CYCLES      (EN),
        .HOLD_CYCLES        (HO),
        .POR_DELAY_CYCLES   (POR),
        .BUSY_TIMEOUT_POLLS (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_rs             (in_rs),
        .lcd_address       (lcd_address),
        .lcd_write         (lcd_write),
        .lcd_read          (lcd_read),
        .lcd_begintransfer (lcd_begintransfer),
        .lcd_writedata     (lcd_writedata),
        .lcd_readdata      (lcd_readdata),
        .init_done         (init_done),
        .busy_timeout      (busy_timeout)
    );

    always #5 clk = ~clk;

    int   vectors = 0, miscompares = 0;
    int   cyc = 0, rd_cnt = 0, w_len = 0;
    int   busy_left = 0, next_busy = 0;
    bit   always_busy = 1'b0;
    logic prev_w = 1'b0, prev_r = 1'b0;
    logic [1:0] prev_addr = 2'b00, w_addr_l = 2'b00;
    logic [7:0] w_data_l = 8'h00;
    logic [9:0] wq[$];        // observed writes: {address, data}
    int         wlen_q[$];    // E width of each observed write
    int         wrise_q[$];   // cycle of each write E rise
    logic [9:0] exp_q[$];
    logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, check bus rules, record transactions and answer reads.
    task automatic step();
        logic we;
        @(posedge clk); #1;
        cyc++;
        we = lcd_write | lcd_read;
        chk("rw_exclusive", 32'(lcd_write & lcd_read), 0);
        chk("begintransfer", 32'(lcd_begintransfer), 32'(we & ~(prev_w | prev_r)));
        if (we && (prev_w || prev_r)) chk("addr_stable", 32'(lcd_address), 32'(prev_addr));
        if (lcd_write && !prev_w) wrise_q.push_back(cyc);
        if (lcd_write) begin
            w_len++;
            w_data_l = lcd_writedata;
            w_addr_l = lcd_address;
        end
        if (!lcd_write && prev_w) begin
            wq.push_back({w_addr_l, w_data_l});
            wlen_q.push_back(w_len);
            w_len = 0;
            busy_left = next_busy;
        end
        if (lcd_read && !prev_r) rd_cnt++;
        if (!lcd_read && prev_r && busy_left > 0) busy_left--;
        lcd_readdata = {(always_busy || busy_left > 0), 7'($urandom)};
        prev_w = lcd_write;
        prev_r = lcd_read;
        prev_addr = lcd_address;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            step();
            n++;
        end
        chk("ready_within_budget", 32'(in_ready), 1);
    endtask

    // Called right after reset_n is released; expects the full init sequence.
    task automatic do_init();
        int s0, rd0;
        s0 = cyc; rd0 = rd_cnt;
        wq.delete(); wlen_q.delete(); wrise_q.delete();
        next_busy = 0; always_busy = 1'b0; busy_left = 0;
        wait_ready(400);
        chk("init_ready_cycle", 32'(cyc - s0), POR + 4 * CMDT);
        if (wrise_q.size() > 0) chk("init_first_e", 32'(wrise_q[0] - s0), POR + 1 + SU);
        else                    chk("init_first_e", 32'hFFFF_FFFF, POR + 1 + SU);
        chk("init_write_count", 32'(wq.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                chk("init_write", 32'(wq[i]), 32'({2'b00, init_tab[i]}));
                chk("init_e_width", 32'(wlen_q[i]), EN);
            end
        end
        chk("init_read_count", 32'(rd_cnt - rd0), 4);
        chk("init_done", 32'(init_done), 1);
        chk("init_timeout", 32'(busy_timeout), 0);
    endtask

    // Send one byte; the LCD reports busy for nbusy polls (or forever when ab).
    task automatic send(input logic [7:0] data, input logic rs, input int nbusy,
                        input bit ab, input logic exp_to);
        int a, rd0, acyc, wcyc, nrd, n;
        next_busy = nbusy; always_busy = ab;
        wq.delete(); wlen_q.delete();
        wait_ready(100);
        rd0 = rd_cnt;
        in_valid = 1'b1; in_data = data; in_rs = rs;
        a = cyc;
        step();
        in_valid = 1'b0; in_data = 8'($urandom); in_rs = 1'($urandom);
        acyc = 0; wcyc = 0; n = 0;
        while (!in_ready && n < 200) begin
            if (lcd_address === {rs, 1'b0}) acyc++;
            if (lcd_write) wcyc++;
            step();
            n++;
        end
        chk("byte_ready", 32'(in_ready), 1);
        nrd = ab ? TO : ((nbusy + 1 < TO) ? nbusy + 1 : TO);
        chk("byte_latency", 32'(cyc - a), 1 + PH * (1 + nrd));
        chk("byte_reads", 32'(rd_cnt - rd0), nrd);
        chk("byte_write_count", 32'(wq.size()), 1);
        if (wq.size() > 0) chk("byte_write", 32'(wq[0]), 32'({rs, 1'b0, data}));
        chk("byte_addr_cycles", 32'(acyc), PH);
        chk("byte_e_cycles", 32'(wcyc), EN);
        chk("byte_timeout", 32'(busy_timeout), 32'(exp_to));
    endtask

    initial begin
        // 1: reset values, then power-on init against a never-busy LCD
        repeat (3) step();
        chk("rst_write", 32'(lcd_write), 0);
        chk("rst_read", 32'(lcd_read), 0);
        chk("rst_bt", 32'(lcd_begintransfer), 0);
        chk("rst_addr", 32'(lcd_address), 0);
        chk("rst_wdata", 32'(lcd_writedata), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_timeout", 32'(busy_timeout), 0);
        reset_n = 1'b1;
        do_init();

        // 2: character 'A'
        send(8'h41, 1'b1, 0, 1'b0, 1'b0);
        // 3: busy for two polls
        send(8'($urandom), 1'b0, 2, 1'b0, 1'b0);
        // random bytes with a random busy depth short of the timeout
        for (int i = 0; i < 6; i++)
            send(8'($urandom), 1'($urandom), int'($urandom_range(0, TO - 1)), 1'b0, 1'b0);
        // 4: LCD stuck busy; the flag is sticky across the next byte
        send(8'($urandom), 1'b1, 0, 1'b1, 1'b1);
        send(8'($urandom), 1'b0, 0, 1'b0, 1'b1);

        // 5: reset in the middle of the 0x0C enable pulse
        reset_n = 1'b0; step(); reset_n = 1'b1;
        always_busy = 1'b0; next_busy = 0; busy_left = 0;
        begin
            int n = 0;
            while (!(lcd_write && lcd_writedata == 8'h0C) && n < 200) begin
                step();
                n++;
            end
        end
        chk("hit_0C_enable", 32'(lcd_write && lcd_writedata == 8'h0C), 1);
        reset_n = 1'b0;
        step();
        chk("midrst_write", 32'(lcd_write), 0);
        chk("midrst_addr", 32'(lcd_address), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_ready", 32'(in_ready), 0);
        chk("midrst_timeout", 32'(busy_timeout), 0);
        reset_n = 1'b1;
        do_init();

        // 6: in_valid held high with data changing every cycle
        wq.delete(); exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            in_rs = 1'($urandom);
            next_busy = int'($urandom_range(0, 1));
            if (in_ready) exp_q.push_back({in_rs, 1'b0, in_data});
            step();
        end
        in_valid = 1'b0;
        wait_ready(200);
        chk("stream_count", 32'(wq.size()), 32'(exp_q.size()));
        chk("stream_nonempty", 32'(exp_q.size() > 5), 1);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < wq.size()) chk("stream_byte", 32'(wq[i]), 32'(exp_q[i]));
        chk("stream_timeout", 32'(busy_timeout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
